// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: default geometry, port
// indices and counter widths.
package mem_arbiter_pkg;

  localparam int AW_DEF         = 10;
  localparam int DW_DEF         = 32;
  localparam int STARVE_MAX_DEF = 4;

  localparam int PORT_CPU  = 0;
  localparam int PORT_DBG  = 1;
  localparam int NUM_PORTS = 2;

  localparam int CNT_W = 16;

  // Width needed to hold 0..max_val inclusive, never narrower than one bit.
  function automatic int starve_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports plus the RAM command/return path.
// The slave side is the arbiter; the master side is requesters and RAM.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_we, ram_addr, ram_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/mem_arbiter_rd_return.sv
// Per-port read return: remembers that this port owns the read in flight,
// pulses rvalid for one cycle and holds the returned word afterwards.
module mem_arbiter_rd_return #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [DW-1:0] ram_dout,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  logic          pending_reg;
  logic [DW-1:0] hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 1'b0;
      hold_reg    <= '0;
    end else begin
      pending_reg <= issue;
      if (pending_reg) begin
        hold_reg <= ram_dout;
      end
    end
  end

  // The RAM word is only valid during the return cycle, so pass it straight
  // through then and serve the captured copy on later cycles.
  assign rvalid = pending_reg;
  assign rdata  = pending_reg ? ram_dout : hold_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-RAM arbiter: CPU port has priority, the debug/DMA port is
// forced through after STARVE_MAX consecutive CPU wins while it waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int SW = starve_width(STARVE_MAX);

  logic [SW-1:0]        starve_cnt_reg;
  logic [SW-1:0]        starve_cnt_next;
  logic [CNT_W-1:0]     conflict_cnt_reg;
  logic [CNT_W-1:0]     conflict_cnt_next;
  logic                 starved;
  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] we_vec;
  logic [NUM_PORTS-1:0] gnt_vec;
  logic [NUM_PORTS-1:0] issue_vec;
  logic [NUM_PORTS-1:0] rvalid_vec;
  logic [AW-1:0]        addr_vec  [NUM_PORTS];
  logic [DW-1:0]        wdata_vec [NUM_PORTS];
  logic [DW-1:0]        rdata_vec [NUM_PORTS];
  logic                 mux_we;
  logic [AW-1:0]        mux_addr;
  logic [DW-1:0]        mux_din;

  assign req_vec[PORT_CPU]   = bus.req0;
  assign req_vec[PORT_DBG]   = bus.req1;
  assign we_vec[PORT_CPU]    = bus.we0;
  assign we_vec[PORT_DBG]    = bus.we1;
  assign addr_vec[PORT_CPU]  = bus.addr0;
  assign addr_vec[PORT_DBG]  = bus.addr1;
  assign wdata_vec[PORT_CPU] = bus.wdata0;
  assign wdata_vec[PORT_DBG] = bus.wdata1;

  assign starved = (starve_cnt_reg == SW'(STARVE_MAX));

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  always_comb begin
    gnt_vec = '0;
    if (!rst) begin
      if (req_vec[PORT_DBG] && (!req_vec[PORT_CPU] || starved)) begin
        gnt_vec[PORT_DBG] = 1'b1;
      end else if (req_vec[PORT_CPU]) begin
        gnt_vec[PORT_CPU] = 1'b1;
      end
    end
  end

  always_comb begin
    mux_we   = 1'b0;
    mux_addr = '0;
    mux_din  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_vec[p]) begin
        mux_we   = we_vec[p];
        mux_addr = addr_vec[p];
        mux_din  = wdata_vec[p];
      end
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (gnt_vec[PORT_DBG] || !req_vec[PORT_DBG]) begin
      starve_cnt_next = '0;
    end else if (gnt_vec[PORT_CPU] && !starved) begin
      starve_cnt_next = starve_cnt_reg + SW'(1);
    end
  end

  always_comb begin
    conflict_cnt_next = conflict_cnt_reg;
    if (req_vec[PORT_CPU] && req_vec[PORT_DBG] && (conflict_cnt_reg != '1)) begin
      conflict_cnt_next = conflict_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg   <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      starve_cnt_reg   <= starve_cnt_next;
      conflict_cnt_reg <= conflict_cnt_next;
    end
  end

  assign issue_vec = gnt_vec & ~we_vec;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rd
    mem_arbiter_rd_return #(
      .DW(DW)
    ) u_rd_return (
      .clk     (clk),
      .rst     (rst),
      .issue   (issue_vec[gi]),
      .ram_dout(bus.ram_dout),
      .rvalid  (rvalid_vec[gi]),
      .rdata   (rdata_vec[gi])
    );
  end

  assign bus.gnt0     = gnt_vec[PORT_CPU];
  assign bus.gnt1     = gnt_vec[PORT_DBG];
  assign bus.rvalid0  = rvalid_vec[PORT_CPU];
  assign bus.rvalid1  = rvalid_vec[PORT_DBG];
  assign bus.rdata0   = rdata_vec[PORT_CPU];
  assign bus.rdata1   = rdata_vec[PORT_DBG];
  assign bus.ram_we   = mux_we;
  assign bus.ram_addr = mux_addr;
  assign bus.ram_din  = mux_din;
  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, per-port queues of
// expected read data, one task per scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] conflict_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp0;
  logic [31:0] exp1;
  logic [31:0] ram [1024];

  mem_arbiter_if #(.AW(10), .DW(32)) bus ();

  mem_arbiter #(
    .AW(10),
    .DW(32),
    .STARVE_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_addr];
  end

  task automatic drive0(input logic rq, input logic w, input logic [9:0] a, input logic [31:0] d);
    bus.req0 = rq; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drive1(input logic rq, input logic w, input logic [9:0] a, input logic [31:0] d);
    bus.req1 = rq; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive0(1'b1, 1'b0, 10'h005, 32'h0);
    drive1(1'b1, 1'b1, 10'h007, 32'h55AA55AA);
    @(negedge clk);
    cmp_cnt++; if (bus.gnt0 !== 1'b0) begin err_cnt++; $display("FAIL reset_gnt0: got %b want 0", bus.gnt0); end
    cmp_cnt++; if (bus.gnt1 !== 1'b0) begin err_cnt++; $display("FAIL reset_gnt1: got %b want 0", bus.gnt1); end
    cmp_cnt++; if (bus.ram_we !== 1'b0) begin err_cnt++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
    cmp_cnt++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin err_cnt++; $display("FAIL reset_rvalid: got %b want 00", {bus.rvalid0, bus.rvalid1}); end
    cmp_cnt++; if (bus.rdata0 !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata0: got %h want 0", bus.rdata0); end
    cmp_cnt++; if (bus.rdata1 !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata1: got %h want 0", bus.rdata1); end
    cmp_cnt++; if (conflict_cnt !== 16'h0) begin err_cnt++; $display("FAIL reset_conflict: got %h want 0", conflict_cnt); end
    next_cycle();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    drive1(1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    cmp_cnt++; if (bus.ram_addr !== 10'h0) begin err_cnt++; $display("FAIL idle_ram_addr: got %h want 0", bus.ram_addr); end
    next_cycle();
    $display("test_reset done");
  endtask

  task automatic test_read_return();
    drive0(1'b1, 1'b1, 10'h005, 32'h12345678);
    @(negedge clk);
    cmp_cnt++; if (bus.gnt0 !== 1'b1 || bus.ram_we !== 1'b1) begin err_cnt++; $display("FAIL rd_prewrite: got gnt0=%b ram_we=%b want 1/1", bus.gnt0, bus.ram_we); end
    next_cycle();
    drive0(1'b1, 1'b0, 10'h005, 32'h0);
    q0.push_back(32'h12345678);
    @(negedge clk);
    cmp_cnt++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin err_cnt++; $display("FAIL rd_gnt: got %b want 10", {bus.gnt0, bus.gnt1}); end
    cmp_cnt++; if (bus.ram_addr !== 10'h005 || bus.ram_we !== 1'b0) begin err_cnt++; $display("FAIL rd_cmd: got addr=%h we=%b want 005/0", bus.ram_addr, bus.ram_we); end
    next_cycle();
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    exp0 = q0.pop_front();
    cmp_cnt++; if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin err_cnt++; $display("FAIL rd_rvalid: got %b%b want 10", bus.rvalid0, bus.rvalid1); end
    cmp_cnt++; if (bus.rdata0 !== exp0) begin err_cnt++; $display("FAIL rd_rdata0: got %h want %h", bus.rdata0, exp0); end
    next_cycle();
    @(negedge clk);
    cmp_cnt++; if (bus.rvalid0 !== 1'b0) begin err_cnt++; $display("FAIL rd_pulse_len: got rvalid0=%b want 0", bus.rvalid0); end
    cmp_cnt++; if (bus.rdata0 !== exp0) begin err_cnt++; $display("FAIL rd_hold: got %h want %h", bus.rdata0, exp0); end
    next_cycle();
    $display("test_read_return done: rdata0=%h", bus.rdata0);
  endtask

  task automatic test_write_read();
    drive1(1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF);
    @(negedge clk);
    cmp_cnt++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin err_cnt++; $display("FAIL wr_gnt: got %b want 01", {bus.gnt0, bus.gnt1}); end
    cmp_cnt++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h3FF || bus.ram_din !== 32'hDEADBEEF) begin
      err_cnt++; $display("FAIL wr_cmd: got we=%b addr=%h din=%h want 1/3ff/deadbeef", bus.ram_we, bus.ram_addr, bus.ram_din);
    end
    next_cycle();
    drive1(1'b1, 1'b0, 10'h3FF, 32'h0);
    q1.push_back(32'hDEADBEEF);
    @(negedge clk);
    cmp_cnt++; if (bus.gnt1 !== 1'b1 || bus.ram_we !== 1'b0) begin err_cnt++; $display("FAIL wr_rd_cmd: got gnt1=%b we=%b want 1/0", bus.gnt1, bus.ram_we); end
    cmp_cnt++; if (bus.rvalid1 !== 1'b0) begin err_cnt++; $display("FAIL wr_no_rvalid: got %b want 0", bus.rvalid1); end
    next_cycle();
    drive1(1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    exp1 = q1.pop_front();
    cmp_cnt++; if (bus.rvalid1 !== 1'b1 || bus.rvalid0 !== 1'b0) begin err_cnt++; $display("FAIL wr_rvalid: got %b%b want 01", bus.rvalid0, bus.rvalid1); end
    cmp_cnt++; if (bus.rdata1 !== exp1) begin err_cnt++; $display("FAIL wr_rdata1: got %h want %h", bus.rdata1, exp1); end
    cmp_cnt++; if (bus.ram_we !== 1'b0) begin err_cnt++; $display("FAIL wr_idle_we: got %b want 0", bus.ram_we); end
    next_cycle();
    $display("test_write_read done: rdata1=%h", bus.rdata1);
  endtask

  task automatic test_alternating();
    drive0(1'b1, 1'b1, 10'h010, 32'hA0A00010);
    next_cycle();
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    drive1(1'b1, 1'b1, 10'h020, 32'hB0B00020);
    next_cycle();
    drive1(1'b0, 1'b0, 10'h0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        if (i % 2 == 0) begin
          drive1(1'b0, 1'b0, 10'h0, 32'h0);
          drive0(1'b1, 1'b0, 10'h010, 32'h0);
          q0.push_back(32'hA0A00010);
        end else begin
          drive0(1'b0, 1'b0, 10'h0, 32'h0);
          drive1(1'b1, 1'b0, 10'h020, 32'h0);
          q1.push_back(32'hB0B00020);
        end
      end else begin
        drive0(1'b0, 1'b0, 10'h0, 32'h0);
        drive1(1'b0, 1'b0, 10'h0, 32'h0);
      end
      @(negedge clk);
      if (i > 0) begin
        if (i % 2 == 1) begin
          exp0 = q0.pop_front();
          cmp_cnt++; if ({bus.rvalid0, bus.rvalid1} !== 2'b10 || bus.rdata0 !== exp0) begin
            err_cnt++; $display("FAIL alt_ret0[%0d]: got rv=%b%b rdata0=%h want 10/%h", i, bus.rvalid0, bus.rvalid1, bus.rdata0, exp0);
          end
        end else begin
          exp1 = q1.pop_front();
          cmp_cnt++; if ({bus.rvalid0, bus.rvalid1} !== 2'b01 || bus.rdata1 !== exp1) begin
            err_cnt++; $display("FAIL alt_ret1[%0d]: got rv=%b%b rdata1=%h want 01/%h", i, bus.rvalid0, bus.rvalid1, bus.rdata1, exp1);
          end
        end
      end
      next_cycle();
    end
    $display("test_alternating done: rdata0=%h rdata1=%h", bus.rdata0, bus.rdata1);
  endtask

  task automatic test_starvation();
    logic exp_g1;
    pulse_reset();
    drive0(1'b1, 1'b0, 10'h010, 32'h0);
    drive1(1'b1, 1'b0, 10'h020, 32'h0);
    for (int i = 0; i < 15; i++) begin
      exp_g1 = (i % 5 == 4);
      @(negedge clk);
      cmp_cnt++; if ({bus.gnt0, bus.gnt1} !== {~exp_g1, exp_g1}) begin
        err_cnt++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, {bus.gnt0, bus.gnt1}, {~exp_g1, exp_g1});
      end
      cmp_cnt++; if (conflict_cnt !== 16'(i)) begin err_cnt++; $display("FAIL starve_conflict[%0d]: got %0d want %0d", i, conflict_cnt, i); end
      next_cycle();
    end
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    drive1(1'b0, 1'b0, 10'h0, 32'h0);
    next_cycle();
    $display("test_starvation done: conflict_cnt=%0d", conflict_cnt);
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 1'b0, 10'h005, 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    cmp_cnt++; if ({bus.gnt0, bus.gnt1, bus.ram_we} !== 3'b000) begin err_cnt++; $display("FAIL rstmid_gnt: got gnt/we=%b want 000", {bus.gnt0, bus.gnt1, bus.ram_we}); end
    cmp_cnt++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin err_cnt++; $display("FAIL rstmid_rvalid: got %b want 00", {bus.rvalid0, bus.rvalid1}); end
    cmp_cnt++; if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin err_cnt++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", bus.rdata0, bus.rdata1); end
    cmp_cnt++; if (conflict_cnt !== 16'h0) begin err_cnt++; $display("FAIL rstmid_conflict: got %h want 0", conflict_cnt); end
    next_cycle();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    cmp_cnt++; if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 32'h0) begin err_cnt++; $display("FAIL rstmid_no_return: got rv0=%b rdata0=%h want 0/0", bus.rvalid0, bus.rdata0); end
    next_cycle();
    drive0(1'b1, 1'b0, 10'h005, 32'h0);
    q0.push_back(32'h12345678);
    @(negedge clk);
    cmp_cnt++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin err_cnt++; $display("FAIL rstmid_regnt: got %b want 10", {bus.gnt0, bus.gnt1}); end
    next_cycle();
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    exp0 = q0.pop_front();
    cmp_cnt++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== exp0) begin err_cnt++; $display("FAIL rstmid_reread: got rv0=%b rdata0=%h want 1/%h", bus.rvalid0, bus.rdata0, exp0); end
    next_cycle();
    $display("test_reset_mid done");
  endtask

  task automatic test_conflict_sat();
    pulse_reset();
    drive0(1'b1, 1'b0, 10'h010, 32'h0);
    drive1(1'b1, 1'b0, 10'h020, 32'h0);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    cmp_cnt++; if (conflict_cnt !== 16'hFFFE) begin err_cnt++; $display("FAIL sat_fffe: got %h want fffe", conflict_cnt); end
    @(posedge clk);
    @(negedge clk);
    cmp_cnt++; if (conflict_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL sat_ffff: got %h want ffff", conflict_cnt); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_cnt++; if (conflict_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
    #1;
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    drive1(1'b0, 1'b0, 10'h0, 32'h0);
    next_cycle();
    $display("test_conflict_sat done: conflict_cnt=%h", conflict_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive0(1'b0, 1'b0, 10'h0, 32'h0);
    drive1(1'b0, 1'b0, 10'h0, 32'h0);
    #1;
    test_reset();
    test_read_return();
    test_write_read();
    test_alternating();
    test_starvation();
    test_reset_mid();
    test_conflict_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
